// File: rtl/mbist_march_ctrl_if.sv
// BIST-side bus between the March controller and the memory mux/repair stage.
// master: the controller (drives strobes, address, data and status; receives run, read data, repair ack).
// slave : the memory mux / repair stage side.
interface mbist_march_ctrl_if #(
  parameter int ADDR_WD = 9,
  parameter int DATA_WD = 32
);
  logic               bist_run;
  logic               bist_en;
  logic [ADDR_WD-1:0] bist_addr;
  logic [DATA_WD-1:0] bist_wdata;
  logic               bist_wr;
  logic               bist_rd;
  logic [DATA_WD-1:0] bist_rdata;
  logic               bist_error;
  logic [ADDR_WD-1:0] bist_error_addr;
  logic               bist_correct;
  logic               bist_done;
  logic               bist_fail;
  logic [3:0]         bist_err_cnt;

  modport master (
    input  bist_run, bist_rdata, bist_correct,
    output bist_en, bist_addr, bist_wdata, bist_wr, bist_rd,
           bist_error, bist_error_addr, bist_done, bist_fail, bist_err_cnt
  );

  modport slave (
    output bist_run, bist_rdata, bist_correct,
    input  bist_en, bist_addr, bist_wdata, bist_wr, bist_rd,
           bist_error, bist_error_addr, bist_done, bist_fail, bist_err_cnt
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST sequencer: writes via port B, reads via port A, reports mismatching addresses for repair.
// Latency: one op per cycle; a read in cycle t raises bist_error in cycle t+2; clean run = 10*N RUN + 2 DRAIN cycles.
// Backpressure: none; bist_run low aborts to IDLE next cycle, repair handshake sampled after 2 ERR_WAIT cycles.
// Ports: bist_clk, rst_n (async active-low) plus the master modport of mbist_march_ctrl_if.
module mbist_march_ctrl #(
  parameter int                      BIST_ADDR_WD    = 9,
  parameter int                      BIST_DATA_WD    = 32,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = 9'h000,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END   = 9'h1F8,
  parameter logic [BIST_DATA_WD-1:0] BIST_PATTERN    = 32'h5555_5555,
  parameter int                      BIST_MAX_REPAIR = 4
) (
  input logic                bist_clk,
  input logic                rst_n,
  mbist_march_ctrl_if.master bif
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_ERR_WAIT, S_DONE} state_t;

  localparam logic [3:0]              LP_MAX_REP = 4'(BIST_MAX_REPAIR);
  localparam logic [BIST_ADDR_WD-1:0] LP_ONE     = {{(BIST_ADDR_WD-1){1'b0}}, 1'b1};

  state_t                  r_state;
  logic [2:0]              r_elem;      // march element of the op on the bus this cycle
  logic                    r_op;        // op index within the element
  logic [BIST_ADDR_WD-1:0] r_addr;
  logic [BIST_DATA_WD-1:0] r_wdata;
  logic                    r_wr;
  logic                    r_rd;
  logic                    r_en;
  logic                    r_done;
  logic                    r_fail;
  logic [3:0]              r_err_cnt;
  logic                    r_error;
  logic [BIST_ADDR_WD-1:0] r_error_addr;
  logic                    r_cmp_vld;   // read data arriving this cycle must be compared
  logic [BIST_DATA_WD-1:0] r_cmp_exp;
  logic [BIST_ADDR_WD-1:0] r_cmp_addr;
  logic                    r_cnt;       // 2-cycle timer for DRAIN and ERR_WAIT

  logic                    w_down;
  logic                    w_two_ops;
  logic                    w_addr_last;
  logic [2:0]              w_nxt_elem;
  logic                    w_nxt_op;
  logic [BIST_ADDR_WD-1:0] w_nxt_addr;
  logic                    w_march_end;
  logic                    w_nxt_rd;
  logic [BIST_DATA_WD-1:0] w_nxt_dat;
  logic [BIST_DATA_WD-1:0] w_cur_exp;
  logic                    w_mis;

  // E1..E5 open with a read; E0 is a lone write, E1..E4 follow the read with a write.
  function automatic logic f_is_rd(input logic [2:0] elem, input logic op);
    return (elem != 3'd0) && !op;
  endfunction

  // Whether the op uses the inverted background: reads of "1" in E2/E4, writes of "1" in E1/E3.
  function automatic logic f_inv(input logic [2:0] elem, input logic op);
    if (f_is_rd(elem, op)) return (elem == 3'd2) || (elem == 3'd4);
    return (elem == 3'd1) || (elem == 3'd3);
  endfunction

  always_comb begin
    w_down      = (r_elem == 3'd3) || (r_elem == 3'd4);
    w_two_ops   = (r_elem != 3'd0) && (r_elem != 3'd5);
    // Boundary compare instead of wrap detection keeps N=1 and END=max-address safe.
    w_addr_last = w_down ? (r_addr == BIST_ADDR_START) : (r_addr == BIST_ADDR_END);
    w_nxt_elem  = r_elem;
    w_nxt_op    = 1'b0;
    w_nxt_addr  = r_addr;
    w_march_end = 1'b0;
    if (w_two_ops && !r_op) begin
      w_nxt_op = 1'b1;
    end else if (!w_addr_last) begin
      w_nxt_addr = w_down ? (r_addr - LP_ONE) : (r_addr + LP_ONE);
    end else if (r_elem == 3'd5) begin
      w_march_end = 1'b1;
    end else begin
      w_nxt_elem = r_elem + 3'd1;
      w_nxt_addr = ((w_nxt_elem == 3'd3) || (w_nxt_elem == 3'd4)) ? BIST_ADDR_END : BIST_ADDR_START;
    end
    w_nxt_rd  = f_is_rd(w_nxt_elem, w_nxt_op);
    w_nxt_dat = f_inv(w_nxt_elem, w_nxt_op) ? ~BIST_PATTERN : BIST_PATTERN;
    w_cur_exp = f_inv(r_elem, r_op) ? ~BIST_PATTERN : BIST_PATTERN;
    w_mis     = r_cmp_vld && (bif.bist_rdata != r_cmp_exp);
  end

  always_ff @(posedge bist_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_elem       <= 3'd0;
      r_op         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_en         <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_err_cnt    <= 4'd0;
      r_error      <= 1'b0;
      r_error_addr <= '0;
      r_cmp_vld    <= 1'b0;
      r_cmp_exp    <= '0;
      r_cmp_addr   <= '0;
      r_cnt        <= 1'b0;
    end else begin
      r_error <= 1'b0;
      if (!bif.bist_run) begin
        // Abort: dropping r_cmp_vld discards any read still in flight.
        r_state   <= S_IDLE;
        r_en      <= 1'b0;
        r_rd      <= 1'b0;
        r_wr      <= 1'b0;
        r_done    <= 1'b0;
        r_fail    <= 1'b0;
        r_cmp_vld <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state   <= S_RUN;
            r_en      <= 1'b1;
            r_err_cnt <= 4'd0;
            r_done    <= 1'b0;
            r_fail    <= 1'b0;
            r_elem    <= 3'd0;
            r_op      <= 1'b0;
            r_addr    <= BIST_ADDR_START;
            r_wr      <= 1'b1;
            r_rd      <= 1'b0;
            r_wdata   <= BIST_PATTERN;
            r_cmp_vld <= 1'b0;
          end
          S_RUN, S_DRAIN: begin
            r_cmp_vld  <= r_rd;
            r_cmp_exp  <= w_cur_exp;
            r_cmp_addr <= r_addr;
            if (w_mis) begin
              // First mismatch wins; later in-flight compares are dropped.
              r_error      <= 1'b1;
              r_error_addr <= r_cmp_addr;
              r_state      <= S_ERR_WAIT;
              r_rd         <= 1'b0;
              r_wr         <= 1'b0;
              r_cmp_vld    <= 1'b0;
              r_cnt        <= 1'b0;
            end else if (r_state == S_RUN) begin
              if (w_march_end) begin
                r_state <= S_DRAIN;
                r_rd    <= 1'b0;
                r_wr    <= 1'b0;
                r_cnt   <= 1'b0;
              end else begin
                r_elem <= w_nxt_elem;
                r_op   <= w_nxt_op;
                r_addr <= w_nxt_addr;
                r_rd   <= w_nxt_rd;
                r_wr   <= !w_nxt_rd;
                if (!w_nxt_rd) r_wdata <= w_nxt_dat;
              end
            end else if (r_cnt) begin
              r_state <= S_DONE;
              r_en    <= 1'b0;
              r_done  <= 1'b1;
              r_fail  <= 1'b0;
            end else begin
              r_cnt <= 1'b1;
            end
          end
          S_ERR_WAIT: begin
            if (!r_cnt) begin
              r_cnt <= 1'b1;
            end else if (bif.bist_correct && (r_err_cnt < LP_MAX_REP)) begin
              if (r_err_cnt != 4'hF) r_err_cnt <= r_err_cnt + 4'd1;
              r_state   <= S_RUN;
              r_elem    <= 3'd0;
              r_op      <= 1'b0;
              r_addr    <= BIST_ADDR_START;
              r_wr      <= 1'b1;
              r_rd      <= 1'b0;
              r_wdata   <= BIST_PATTERN;
              r_cmp_vld <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_en    <= 1'b0;
              r_done  <= 1'b1;
              r_fail  <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_DONE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bif.bist_en         = r_en;
  assign bif.bist_addr       = r_addr;
  assign bif.bist_wdata      = r_wdata;
  assign bif.bist_wr         = r_wr;
  assign bif.bist_rd         = r_rd;
  assign bif.bist_error      = r_error;
  assign bif.bist_error_addr = r_error_addr;
  assign bif.bist_done       = r_done;
  assign bif.bist_fail       = r_fail;
  assign bif.bist_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl with N=16 (addresses 0x000..0x00F): SRAM model with stuck-at faults,
// repair responder, per-cycle op table for a clean run, directed fault/abort/reset sequences and
// randomized fault sets checked against an op-list reference model of the March C- test.
module tb_mbist_march_ctrl;
  localparam int          AW   = 9;
  localparam int          DW   = 32;
  localparam int          N    = 16;
  localparam int          NOPS = 10 * N;
  localparam int          MAXR = 4;
  localparam logic [31:0] P    = 32'h5555_5555;
  localparam int          W0 = 1, W1 = 2, R0 = 3, R1 = 4;

  logic bist_clk = 1'b0;
  logic rst_n    = 1'b0;
  always #5 bist_clk = ~bist_clk;

  mbist_march_ctrl_if #(.ADDR_WD(AW), .DATA_WD(DW)) bif ();

  mbist_march_ctrl #(
    .BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .BIST_ADDR_START(9'h000), .BIST_ADDR_END(9'h00F),
    .BIST_PATTERN(P), .BIST_MAX_REPAIR(MAXR)
  ) dut (
    .bist_clk(bist_clk), .rst_n(rst_n), .bif(bif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // SRAM with per-address stuck-at faults applied on read; synchronous read (data next cycle).
  logic [31:0] mem   [0:511];
  logic [31:0] fmask [0:511];
  logic [31:0] fval  [0:511];

  always @(posedge bist_clk) begin
    if (bif.bist_wr) mem[bif.bist_addr] = bif.bist_wdata;
    if (bif.bist_rd)
      bif.bist_rdata <= (mem[bif.bist_addr] & ~fmask[bif.bist_addr]) |
                        (fval[bif.bist_addr] & fmask[bif.bist_addr]);
  end

  task automatic clear_faults();
    for (int i = 0; i < 512; i++) begin
      fmask[i] = 32'h0;
      fval[i]  = 32'h0;
    end
  endtask

  task automatic add_fault(input int a, input int b, input bit v);
    fmask[a][b] = 1'b1;
    fval[a][b]  = v;
  endtask

  // Reference: flat op list of March C- built from the element table.
  int op_code [NOPS];
  int op_addr [NOPS];

  task automatic build_ops();
    int el_up  [6] = '{1, 1, 1, 0, 0, 1};
    int el_ops [6][2] = '{'{W0, 0}, '{R0, W1}, '{R1, W0}, '{R0, W1}, '{R1, W0}, '{R0, 0}};
    int k = 0;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++)
        for (int o = 0; o < 2; o++)
          if (el_ops[e][o] != 0) begin
            op_code[k] = el_ops[e][o];
            op_addr[k] = (el_up[e] != 0) ? i : (N - 1 - i);
            k++;
          end
  endtask

  int exp_addr[$];
  int exp_cyc[$];
  int exp_done;
  int exp_cnt;
  bit exp_fail;

  // Replays the march over a model memory; each repaired run restarts from op 0.
  task automatic run_model(input bit corr);
    logic [31:0] mk [N];
    logic [31:0] vl [N];
    logic [31:0] mv [N];
    logic [31:0] rv, want;
    int base = 0;
    int cnt  = 0;
    int mis;
    exp_addr.delete();
    exp_cyc.delete();
    for (int a = 0; a < N; a++) begin
      mk[a] = fmask[a];
      vl[a] = fval[a];
      mv[a] = 32'h0;
    end
    forever begin
      mis = -1;
      for (int k = 0; k < NOPS; k++) begin
        if (op_code[k] == W0 || op_code[k] == W1) begin
          mv[op_addr[k]] = (op_code[k] == W1) ? ~P : P;
        end else begin
          rv   = (mv[op_addr[k]] & ~mk[op_addr[k]]) | (vl[op_addr[k]] & mk[op_addr[k]]);
          want = (op_code[k] == R1) ? ~P : P;
          if (rv != want) begin
            mis = k;
            break;
          end
        end
      end
      if (mis < 0) begin
        exp_done = base + NOPS + 3;
        exp_fail = 1'b0;
        break;
      end
      exp_addr.push_back(op_addr[mis]);
      exp_cyc.push_back(base + mis + 3);
      if (corr && cnt < MAXR) begin
        cnt++;
        mk[op_addr[mis]] = 32'h0;
        base = base + mis + 4;
      end else begin
        exp_fail = 1'b1;
        exp_done = base + mis + 5;
        break;
      end
    end
    exp_cnt = cnt;
  endtask

  // Per-cycle trace of the latest run (cycle 1 = first cycle after bist_run is sampled).
  logic        tr_wr [0:199];
  logic        tr_rd [0:199];
  logic        tr_en [0:199];
  logic [8:0]  tr_addr [0:199];
  logic [31:0] tr_wdata [0:199];
  int          obs_first_addr, obs_first_cyc;
  logic        obs_fail;
  logic [3:0]  obs_cnt;

  // Call at posedge+1 with bist_run low.
  task automatic run_case(input string tag, input bit corr);
    int cyc = 0, en_cnt = 0, nerr = 0;
    run_model(corr);
    bif.bist_correct = corr;
    bif.bist_run     = 1'b1;
    obs_first_addr   = -1;
    obs_first_cyc    = -1;
    while (cyc < 3000) begin
      @(posedge bist_clk); #1;
      cyc++;
      if (cyc < 200) begin
        tr_wr[cyc] = bif.bist_wr;  tr_rd[cyc] = bif.bist_rd;  tr_en[cyc] = bif.bist_en;
        tr_addr[cyc] = bif.bist_addr;  tr_wdata[cyc] = bif.bist_wdata;
      end
      if (bif.bist_en) en_cnt++;
      if (bif.bist_error) begin
        if (nerr == 0) begin
          obs_first_addr = int'(bif.bist_error_addr);
          obs_first_cyc  = cyc;
        end
        if (nerr < exp_addr.size()) begin
          chk({tag, " err_addr"}, bif.bist_error_addr, exp_addr[nerr]);
          chk({tag, " err_cyc"}, cyc, exp_cyc[nerr]);
        end else begin
          chk({tag, " unexpected bist_error"}, bif.bist_error, 0);
        end
        if (corr) fmask[bif.bist_error_addr] = 32'h0;  // repair stage remaps the row
        nerr++;
      end
      if (bif.bist_done) break;
    end
    chk({tag, " done_cyc"}, cyc, exp_done);
    chk({tag, " n_errors"}, nerr, exp_addr.size());
    chk({tag, " fail"}, bif.bist_fail, exp_fail);
    chk({tag, " err_cnt"}, bif.bist_err_cnt, exp_cnt);
    chk({tag, " en_cycles"}, en_cnt, exp_done - 1);
    obs_fail = bif.bist_fail;
    obs_cnt  = bif.bist_err_cnt;
    repeat (2) @(posedge bist_clk); #1;
    chk({tag, " done held"}, {bif.bist_done, bif.bist_fail, bif.bist_err_cnt},
        {1'b1, exp_fail, 4'(exp_cnt)});
    bif.bist_run = 1'b0;
    @(posedge bist_clk); #1;
    chk({tag, " idle outs"}, {bif.bist_done, bif.bist_fail, bif.bist_en, bif.bist_rd, bif.bist_wr}, 0);
    chk({tag, " idle err_cnt"}, bif.bist_err_cnt, exp_cnt);
    clear_faults();
  endtask

  typedef struct {
    int          cyc;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t tv [15];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    tv[0]  = '{1,   1'b1, 1'b0, 9'h000, 32'h5555_5555};
    tv[1]  = '{16,  1'b1, 1'b0, 9'h00F, 32'h5555_5555};
    tv[2]  = '{17,  1'b0, 1'b1, 9'h000, 32'h5555_5555};
    tv[3]  = '{18,  1'b1, 1'b0, 9'h000, 32'hAAAA_AAAA};
    tv[4]  = '{19,  1'b0, 1'b1, 9'h001, 32'hAAAA_AAAA};
    tv[5]  = '{48,  1'b1, 1'b0, 9'h00F, 32'hAAAA_AAAA};
    tv[6]  = '{49,  1'b0, 1'b1, 9'h000, 32'hAAAA_AAAA};
    tv[7]  = '{50,  1'b1, 1'b0, 9'h000, 32'h5555_5555};
    tv[8]  = '{81,  1'b0, 1'b1, 9'h00F, 32'h5555_5555};
    tv[9]  = '{82,  1'b1, 1'b0, 9'h00F, 32'hAAAA_AAAA};
    tv[10] = '{112, 1'b1, 1'b0, 9'h000, 32'hAAAA_AAAA};
    tv[11] = '{113, 1'b0, 1'b1, 9'h00F, 32'hAAAA_AAAA};
    tv[12] = '{114, 1'b1, 1'b0, 9'h00F, 32'h5555_5555};
    tv[13] = '{145, 1'b0, 1'b1, 9'h000, 32'h5555_5555};
    tv[14] = '{160, 1'b0, 1'b1, 9'h00F, 32'h5555_5555};

    bif.bist_run = 1'b0;
    bif.bist_correct = 1'b0;
    clear_faults();
    build_ops();

    // Reset values
    repeat (2) @(posedge bist_clk); #1;
    chk("reset ctrl outs", {bif.bist_en, bif.bist_wr, bif.bist_rd, bif.bist_error,
                            bif.bist_done, bif.bist_fail, bif.bist_err_cnt}, 0);
    chk("reset addr", bif.bist_addr, 0);
    chk("reset wdata", bif.bist_wdata, 0);
    chk("reset err_addr", bif.bist_error_addr, 0);
    rst_n = 1'b1;
    @(posedge bist_clk); #1;

    // Clean run with per-cycle op table
    run_case("clean", 1'b1);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("op c%0d wr", tv[i].cyc), tr_wr[tv[i].cyc], tv[i].wr);
      chk($sformatf("op c%0d rd", tv[i].cyc), tr_rd[tv[i].cyc], tv[i].rd);
      chk($sformatf("op c%0d addr", tv[i].cyc), tr_addr[tv[i].cyc], tv[i].addr);
      chk($sformatf("op c%0d wdata", tv[i].cyc), tr_wdata[tv[i].cyc], tv[i].wdata);
      chk($sformatf("op c%0d en", tv[i].cyc), tr_en[tv[i].cyc], 1);
    end
    chk("drain1 rd/wr/en", {tr_rd[161], tr_wr[161], tr_en[161]}, 3'b001);
    chk("drain2 en", tr_en[162], 1);
    chk("done cycle en", tr_en[163], 0);
    chk("clean no error", obs_first_cyc, -1);

    // Stuck-at-1 bit 1 at 0x005, repaired
    add_fault(5, 1, 1'b1);
    run_case("sa1 repaired", 1'b1);
    chk("sa1 repaired first addr", obs_first_addr, 5);
    chk("sa1 repaired first cyc (E1)", obs_first_cyc, 29);
    chk("sa1 repaired fail/cnt", {obs_fail, obs_cnt}, {1'b0, 4'd1});

    // Same fault, no repair
    add_fault(5, 1, 1'b1);
    run_case("sa1 unrepaired", 1'b0);
    chk("sa1 unrepaired first addr", obs_first_addr, 5);
    chk("sa1 unrepaired fail/cnt", {obs_fail, obs_cnt}, {1'b1, 4'd0});

    // Five faulty addresses exceed the repair budget
    for (int i = 0; i < 5; i++) add_fault(1 + 3 * i, 1, 1'b1);
    run_case("five faults", 1'b1);
    chk("five faults fail/cnt", {obs_fail, obs_cnt}, {1'b1, 4'd4});

    // Abort at cycle 40 while a mismatching read (0x00B, cycle 39) is in flight
    add_fault(11, 1, 1'b1);
    bif.bist_correct = 1'b1;
    bif.bist_run = 1'b1;
    seen = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge bist_clk); #1;
      if (bif.bist_error) seen++;
    end
    bif.bist_run = 1'b0;
    @(posedge bist_clk); #1;
    chk("abort idle outs", {bif.bist_en, bif.bist_rd, bif.bist_wr, bif.bist_done}, 0);
    for (int c = 0; c < 5; c++) begin
      if (bif.bist_error) seen++;
      @(posedge bist_clk); #1;
    end
    chk("abort no bist_error", seen, 0);
    clear_faults();

    // Async reset mid-RUN
    bif.bist_run = 1'b1;
    repeat (50) @(posedge bist_clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst ctrl outs", {bif.bist_en, bif.bist_wr, bif.bist_rd, bif.bist_error,
                                bif.bist_done, bif.bist_fail, bif.bist_err_cnt}, 0);
    chk("async rst addr/wdata", {bif.bist_addr, bif.bist_wdata}, 0);
    bif.bist_run = 1'b0;
    @(posedge bist_clk); #1;
    rst_n = 1'b1;
    @(posedge bist_clk); #1;

    // Randomized fault sets against the reference model
    for (int r = 0; r < 6; r++) begin
      int nf;
      bit corr;
      nf   = $urandom_range(0, 5);
      corr = 1'($urandom_range(0, 1));
      for (int f = 0; f < nf; f++)
        add_fault($urandom_range(0, N - 1), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
      run_case($sformatf("rand%0d", r), corr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- Upstream MBIST sequencer that drives the BIST side of the memory mux/repair stage.
- Runs a March C- algorithm over one dual-port SRAM: writes through port B and reads back through port A.
- Compares read data against the expected pattern and reports each mismatching address for repair.
- Restarts the march after every successful repair; reports pass/fail and the repair count.

Parameters:
- BIST_ADDR_WD, 9, address width.
- BIST_DATA_WD, 32, data width.
- BIST_ADDR_START, 9'h000, first tested address.
- BIST_ADDR_END, 9'h1F8, last tested address (inclusive).
- BIST_PATTERN, 32'h5555_5555, background pattern. "0" = BIST_PATTERN, "1" = ~BIST_PATTERN.
- BIST_MAX_REPAIR, 4, maximum corrected errors before forced fail.

Ports:
- bist_clk  in  1  BIST clock; the only clock.
- rst_n  in  1  async active-low reset.
- bist_run  in  1  level; high = run test, low = abort/clear.
- bist_en  out  1  selects the BIST path in the memory mux.
- bist_addr  out  BIST_ADDR_WD  shared port A/B address.
- bist_wdata  out  BIST_DATA_WD  write data.
- bist_wr  out  1  write strobe, one cycle per write op.
- bist_rd  out  1  read strobe, one cycle per read op.
- bist_rdata  in  BIST_DATA_WD  port A read data, valid the cycle after bist_rd.
- bist_error  out  1  one-cycle mismatch pulse.
- bist_error_addr  out  BIST_ADDR_WD  failing address; valid while bist_error=1.
- bist_correct  in  1  repair stage reports the failing address was remapped.
- bist_done  out  1  test finished (pass or fail).
- bist_fail  out  1  test failed; valid when bist_done=1.
- bist_err_cnt  out  4  number of corrected errors, saturating at 15.

Behaviour:
- Reset: state IDLE; every output 0, including bist_addr and bist_wdata.
- States: IDLE, RUN, DRAIN, ERR_WAIT, DONE.
- IDLE -> RUN when bist_run is sampled high. The element counter, address and bist_err_cnt clear on this transition.
- March elements, one op per cycle, back-to-back, in this order:
  - E0 up (w0)
  - E1 up (r0,w1)
  - E2 up (r1,w0)
  - E3 down (r0,w1)
  - E4 down (r1,w0)
  - E5 up (r0)
- Addressing:
  - "up" runs START..END; "down" runs END..START, step 1.
  - All ops of an element complete at one address before the address moves.
- Op cycle timing:
  - Read op: bist_rd=1, bist_wr=0.
  - Write op: bist_wr=1, bist_rd=0, bist_wdata = pattern.
  - bist_wdata holds its last value on read cycles.
- RUN lasts exactly 10*N cycles, where N = END-START+1.
- RUN -> DRAIN after the last E5 read. DRAIN lasts 2 cycles, then DONE.
- Compare pipeline:
  - A read in cycle t registers its expected data and address.
  - bist_rdata is compared in cycle t+1.
  - On mismatch, bist_error=1 with bist_error_addr in cycle t+2, for exactly one cycle.
- On a registered mismatch (in RUN or DRAIN):
  - Next state is ERR_WAIT; bist_rd and bist_wr are forced to 0.
  - Compare results of reads already in flight are discarded.
  - Only the first mismatch is reported.
- ERR_WAIT lasts 2 cycles, then bist_correct is sampled:
  - bist_correct=1 and bist_err_cnt < BIST_MAX_REPAIR: increment bist_err_cnt, restart RUN at E0, address START.
  - Otherwise: go to DONE with bist_fail=1.
- bist_en=1 in RUN, DRAIN and ERR_WAIT; 0 in IDLE and DONE.
- DONE: bist_done=1, bist_fail held, bist_err_cnt held, for as long as bist_run=1.
- bist_run sampled low in any state -> IDLE next cycle. In IDLE, bist_done, bist_fail, bist_en, bist_rd and bist_wr are 0; bist_err_cnt holds its value until the next start.
- Mid-run abort: bist_error is not issued for reads still in flight.
- rst_n asserted at any time: immediate return to reset values.
- N=1 is legal: an up element and a down element are the same single address.
- Up/down address counters must not wrap past START/END.

Test Plan:
- Clean run, END=9'h00F (N=16), bist_run=1 -> bist_en=1 for 162 cycles; bist_done rises 162 cycles after the sampling edge; bist_fail=0, bist_err_cnt=0, no bist_error pulse.
- Op ordering, N=16:
  - First cycle: bist_wr=1, addr 0x000, wdata 32'h5555_5555.
  - Cycle 17: bist_rd=1, addr 0x000.
  - Cycle 18: bist_wr=1, addr 0x000, wdata 32'hAAAA_AAAA.
  - First E3 op: bist_rd=1, addr 0x00F.
- Stuck-at-1 on bit 1 at addr 0x005, bist_correct=1 -> single bist_error pulse, error_addr=0x005, during E1; restart; bist_done=1, bist_fail=0, bist_err_cnt=1.
- Same fault with bist_correct=0 -> bist_error at 0x005, then bist_done=1, bist_fail=1, bist_err_cnt=0.
- Five distinct faulty addresses with bist_correct=1, BIST_MAX_REPAIR=4 -> bist_err_cnt=4, fifth error gives bist_fail=1.
- Abort: bist_run drops at cycle 40 -> next cycle IDLE, bist_en=0, rd=wr=0, no bist_error. Async rst_n pulse mid-RUN -> all outputs 0 immediately.
